// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage: FSM states, reset PC and
// instruction field bounds.
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam int          OP_MSB   = 31;
  localparam int          OP_LSB   = 26;
  localparam int          PC_INCR  = 4;

endpackage

// File: rtl/pc_register.sv
// Program counter flop: asynchronous active-high reset to a fixed address,
// loads D when enabled.
module pc_register #(
  parameter int                NBITS     = 32,
  parameter logic [NBITS-1:0]  RESET_VAL = NBITS'(32'h0040_0000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic [NBITS-1:0] i_d,
  output logic [NBITS-1:0] o_q
);

  logic [NBITS-1:0] r_q;

  // PC storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= RESET_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: issues one instruction-memory read per instruction, holds
// the returned word for the decoder and selects the next PC from branch flags.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int               NBITS    = 32,
  parameter logic [NBITS-1:0] RESET_PC = NBITS'(mips_pkg::RESET_PC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Stall,
  input  logic             BranchEQ,
  input  logic             BranchNE,
  input  logic             Zero,
  input  logic [NBITS-1:0] BranchTarget,
  output logic             IMemReq,
  output logic [NBITS-1:0] IMemAddr,
  input  logic             IMemValid,
  input  logic [NBITS-1:0] IMemData,
  output logic [NBITS-1:0] Instruction,
  output logic [5:0]       OP,
  output logic [NBITS-1:0] PC_4,
  output logic             InstrValid
);

  fetch_state_t     r_state;
  fetch_state_t     w_next_state;
  logic             w_issue;
  logic             w_capture;
  logic             w_advance;
  logic             w_taken;
  logic [NBITS-1:0] w_pc;
  logic [NBITS-1:0] w_pc_plus4;
  logic [NBITS-1:0] w_branch_pc;
  logic [NBITS-1:0] w_pc_next;

  logic             r_req;
  logic [NBITS-1:0] r_addr;
  logic [NBITS-1:0] r_instr;
  logic [NBITS-1:0] r_pc4;
  logic             r_valid;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; Stall only matters once an instruction is held
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FETCH:   w_next_state = WAIT;
      WAIT:    w_next_state = IMemValid ? HOLD : WAIT;
      HOLD:    w_next_state = Stall ? HOLD : FETCH;
      default: w_next_state = FETCH;
    endcase
  end

  // State-decoded control strobes
  always_comb begin
    w_issue   = 1'b0;
    w_capture = 1'b0;
    w_advance = 1'b0;
    case (r_state)
      FETCH:   w_issue   = 1'b1;
      WAIT:    w_capture = IMemValid;
      HOLD:    w_advance = ~Stall;
      default: w_issue   = 1'b0;
    endcase
  end

  // Both branch flags together form an unconditional branch
  assign w_taken     = (BranchEQ & Zero) | (BranchNE & ~Zero);
  assign w_pc_plus4  = w_pc + NBITS'(PC_INCR);
  assign w_branch_pc = BranchTarget & {{(NBITS-2){1'b1}}, 2'b00};
  assign w_pc_next   = w_taken ? w_branch_pc : w_pc_plus4;

  pc_register #(
    .NBITS     (NBITS),
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_advance),
    .i_d   (w_pc_next),
    .o_q   (w_pc)
  );

  // Registered memory request and captured instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req   <= 1'b0;
      r_addr  <= RESET_PC;
      r_instr <= '0;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_req <= w_issue;
      if (w_issue) begin
        r_addr <= w_pc;
      end
      if (w_capture) begin
        r_instr <= IMemData;
        r_pc4   <= w_pc_plus4;
        r_valid <= 1'b1;
      end else if (w_advance) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign IMemReq     = r_req;
  assign IMemAddr    = r_addr;
  assign Instruction = r_instr;
  assign OP          = r_instr[OP_MSB:OP_LSB];
  assign PC_4        = r_pc4;
  assign InstrValid  = r_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed and random instruction
// sequences against a transaction-level PC/branch model.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        Stall;
  logic        BranchEQ;
  logic        BranchNE;
  logic        Zero;
  logic [31:0] BranchTarget;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemValid;
  logic [31:0] IMemData;
  logic [31:0] Instruction;
  logic [5:0]  OP;
  logic [31:0] PC_4;
  logic        InstrValid;

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_pc;

  instruction_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .Stall        (Stall),
    .BranchEQ     (BranchEQ),
    .BranchNE     (BranchNE),
    .Zero         (Zero),
    .BranchTarget (BranchTarget),
    .IMemReq      (IMemReq),
    .IMemAddr     (IMemAddr),
    .IMemValid    (IMemValid),
    .IMemData     (IMemData),
    .Instruction  (Instruction),
    .OP           (OP),
    .PC_4         (PC_4),
    .InstrValid   (InstrValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic junk_branch();
    BranchEQ     = 1'($urandom_range(1, 0));
    BranchNE     = 1'($urandom_range(1, 0));
    Zero         = 1'($urandom_range(1, 0));
    BranchTarget = $urandom;
  endtask

  // One instruction, entered at a negedge while the DUT sits in FETCH.
  // lat = cycles from request to return (>=1); stalls = extra HOLD cycles.
  task automatic run_instr(input logic [31:0] data, input int lat, input int stalls,
                           input logic beq, input logic bne, input logic zero,
                           input logic [31:0] target);
    logic taken;
    check1("fetch_req_low", IMemReq, 1'b0);
    check1("fetch_valid_low", InstrValid, 1'b0);
    step();
    IMemValid = 1'b0;
    Stall     = 1'($urandom_range(1, 0));
    check1("req_pulse", IMemReq, 1'b1);
    check("req_addr", IMemAddr, exp_pc);
    for (int k = 0; k < lat; k++) begin
      step();
      Stall = 1'($urandom_range(1, 0));
      check1("wait_req_low", IMemReq, 1'b0);
      check1("wait_valid_low", InstrValid, 1'b0);
    end
    IMemValid = 1'b1;
    IMemData  = data;
    step();
    // now in HOLD: returns here must be ignored
    IMemValid = 1'($urandom_range(1, 0));
    IMemData  = $urandom;
    Stall     = (stalls > 0);
    if (stalls > 0) junk_branch();
    else begin
      BranchEQ = beq; BranchNE = bne; Zero = zero; BranchTarget = target;
    end
    check1("hold_valid", InstrValid, 1'b1);
    check("hold_instr", Instruction, data);
    check("hold_op", {26'd0, OP}, {26'd0, data[31:26]});
    check("hold_pc4", PC_4, exp_pc + 32'd4);
    check1("hold_req_low", IMemReq, 1'b0);
    for (int s = 0; s < stalls; s++) begin
      step();
      IMemValid = 1'($urandom_range(1, 0));
      IMemData  = $urandom;
      if (s == stalls - 1) begin
        Stall = 1'b0;
        BranchEQ = beq; BranchNE = bne; Zero = zero; BranchTarget = target;
      end else begin
        junk_branch();
      end
      check1("stall_valid", InstrValid, 1'b1);
      check("stall_instr", Instruction, data);
      check("stall_pc4", PC_4, exp_pc + 32'd4);
      check1("stall_req_low", IMemReq, 1'b0);
      check("stall_addr", IMemAddr, exp_pc);
    end
    step();
    taken  = (beq && zero) || (bne && !zero);
    exp_pc = taken ? {target[31:2], 2'b00} : exp_pc + 32'd4;
    junk_branch();
    Stall = 1'($urandom_range(1, 0));
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b1;
    Stall        = 1'b0;
    BranchEQ     = 1'b0;
    BranchNE     = 1'b0;
    Zero         = 1'b0;
    BranchTarget = 32'd0;
    IMemValid    = 1'b0;
    IMemData     = 32'd0;
    exp_pc       = 32'h0040_0000;
    repeat (3) step();
    check1("rst_req", IMemReq, 1'b0);
    check("rst_addr", IMemAddr, 32'h0040_0000);
    check("rst_instr", Instruction, 32'd0);
    check("rst_op", {26'd0, OP}, 32'd0);
    check("rst_pc4", PC_4, 32'd0);
    check1("rst_valid", InstrValid, 1'b0);
    reset = 1'b0;

    // first instruction, then a second sequential one
    run_instr(32'h2008_0005, 1, 0, 1'b0, 1'b0, 1'b0, 32'd0);
    run_instr($urandom, 1, 0, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
    check("seq_pc", exp_pc, 32'h0040_0008);
    // BNE taken, then BNE not taken
    run_instr($urandom, 1, 0, 1'b0, 1'b1, 1'b0, 32'h0040_0023);
    run_instr($urandom, 2, 0, 1'b0, 1'b1, 1'b1, 32'h0040_0023);
    // 4-cycle stall, then BEQ+BNE together (always taken)
    run_instr($urandom, 1, 4, 1'b1, 1'b1, 1'b1, 32'h0040_0100);
    run_instr($urandom, 3, 0, 1'b1, 1'b1, 1'b0, 32'h0040_0200);

    // reset while a request is outstanding, stale return right after release
    step();
    check1("pre_rst_req", IMemReq, 1'b1);
    reset = 1'b1;
    #1;
    check1("async_rst_req", IMemReq, 1'b0);
    check1("async_rst_valid", InstrValid, 1'b0);
    @(negedge clk);
    check("rst2_addr", IMemAddr, 32'h0040_0000);
    check("rst2_instr", Instruction, 32'd0);
    reset     = 1'b0;
    IMemValid = 1'b1;
    IMemData  = 32'hDEAD_BEEF;
    exp_pc    = 32'h0040_0000;
    run_instr(32'h0000_0020, 1, 0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    // PC at top of address space wraps
    run_instr($urandom, 1, 0, 1'b0, 1'b0, 1'b0, 32'd0);
    check("wrap_pc", exp_pc, 32'd0);
    run_instr($urandom, 1, 1, 1'b0, 1'b0, 1'b0, 32'd0);

    // random traffic
    for (int i = 0; i < 30; i++) begin
      run_instr($urandom, int'($urandom_range(4, 1)), int'($urandom_range(3, 0)),
                1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                1'($urandom_range(1, 0)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
